// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a ready/valid byte input.
// Ports:
//   clk_i, rst_i (async, active-high)
//   valid_i, ready_o, data_i[7:0]: byte handshake
//   tx_o: serial line (idles high)
//   busy_o: frame in progress
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1).
module uart_tx #(
  parameter int ClkFreqHz = 12_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int ClksPerBit = ClkFreqHz / BaudRate;
  localparam int CntW = (ClksPerBit < 2) ? 1 :
                        $clog2(ClksPerBit);
  localparam logic [CntW-1:0] CntLast =
    CntW'(ClksPerBit - 1);

  if (ClksPerBit < 2) begin : g_chk
    $error("uart_tx: ClksPerBit must be >= 2");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_PAR   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            bit_end;
  logic            hs;

`ifdef UART_TX_PARITY_EN
  // The shift register is consumed as bits go
  // out, so parity is captured at load time.
  logic par_q, par_d;
`endif

  assign bit_end = (cnt_q == CntLast);
  assign ready_o = (state_q == S_IDLE) ||
                   (state_q == S_STOP && bit_end);
  assign hs      = valid_i && ready_o;
  assign tx_o    = tx_q;
  assign busy_o  = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PAR;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PAR: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
    // A handshake in Idle or in the last stop
    // cycle starts the next frame on this edge.
    if (hs) begin
      state_d = S_START;
      cnt_d   = '0;
      idx_d   = 3'd0;
      shift_d = data_i;
      tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = ^data_i;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx
// with ClksPerBit = 4.
module tb_uart_tx;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_i;
  logic       tx_o;
  logic       busy_o;

  int n_vec = 0;
  int n_err = 0;

  // Frame bit j of each vector is bit j of the
  // constant: start, d0..d7, [parity], stop.
`ifdef UART_TX_PARITY_EN
  localparam int FL = 44;
  localparam logic [10:0] F_A5 =
    {1'b1, 1'b0, 8'hA5, 1'b0};
  localparam logic [10:0] F_5A =
    {1'b1, 1'b0, 8'h5A, 1'b0};
  localparam logic [10:0] F_00 =
    {1'b1, 1'b0, 8'h00, 1'b0};
  localparam logic [10:0] F_3C =
    {1'b1, 1'b0, 8'h3C, 1'b0};
  localparam logic [10:0] F_07 =
    {1'b1, 1'b1, 8'h07, 1'b0};
`else
  localparam int FL = 40;
  localparam logic [10:0] F_A5 =
    {1'b0, 10'b1101001010};
  localparam logic [10:0] F_5A =
    {1'b0, 10'b1010110100};
  localparam logic [10:0] F_00 =
    {1'b0, 10'b1000000000};
  localparam logic [10:0] F_3C =
    {1'b0, 10'b1001111000};
`endif

  uart_tx #(
    .ClkFreqHz(1_000_000),
    .BaudRate (250_000)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i (data_i),
    .tx_o   (tx_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Called just after the handshake edge; walks
  // FL cycles, checking one sample per bit.
  task automatic frame(input string tag,
                       input logic [10:0] exp,
                       input bit wiggle,
                       output int busy_n,
                       output logic rdy_last,
                       output int early_rdy);
    busy_n    = 0;
    early_rdy = 0;
    rdy_last  = 1'b0;
    for (int c = 0; c < FL; c++) begin
      if (c % 4 == 0)
        check($sformatf("%s_bit%0d", tag, c / 4),
              32'(tx_o), 32'(exp[c / 4]));
      if (busy_o) busy_n++;
      if (c < FL - 1 && ready_o) early_rdy++;
      if (c == FL - 1) rdy_last = ready_o;
      if (wiggle) begin
        data_i  = 8'hFF;
        valid_i = (c < FL - 2) && c[0];
      end
      step();
    end
  endtask

  int   bn, er;
  logic rl;
  bit   idle_ok;

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    data_i  = 8'h00;
    #2;
    check("rst_tx", 32'(tx_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    step();
    step();
    rst_i = 1'b0;

    idle_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if ({tx_o, busy_o, ready_o} !== 3'b101)
        idle_ok = 1'b0;
    end
    check("idle_hold", 32'(idle_ok), 32'd1);

    // Single byte
    valid_i = 1'b1;
    data_i  = 8'hA5;
    step();
    valid_i = 1'b0;
    frame("a5", F_A5, 1'b0, bn, rl, er);
    check("a5_busy_n", bn, FL);
    check("a5_rdy_last", 32'(rl), 32'd1);
    check("a5_early_rdy", er, 0);
    check("a5_end_busy", 32'(busy_o), 32'd0);
    check("a5_end_ready", 32'(ready_o), 32'd1);
    check("a5_end_tx", 32'(tx_o), 32'd1);
    step();

    // Back-to-back with valid held high
    valid_i = 1'b1;
    data_i  = 8'hA5;
    step();
    data_i = 8'h5A;
    frame("b2b1", F_A5, 1'b0, bn, rl, er);
    valid_i = 1'b0;
    check("b2b1_busy_n", bn, FL);
    check("b2b1_rdy_last", 32'(rl), 32'd1);
    check("b2b_gap_busy", 32'(busy_o), 32'd1);
    frame("b2b2", F_5A, 1'b0, bn, rl, er);
    check("b2b2_busy_n", bn, FL);
    check("b2b2_end_busy", 32'(busy_o), 32'd0);
    step();

    // Input stability under data/valid churn
    valid_i = 1'b1;
    data_i  = 8'h00;
    step();
    valid_i = 1'b0;
    frame("stab", F_00, 1'b1, bn, rl, er);
    valid_i = 1'b0;
    check("stab_early_rdy", er, 0);
    check("stab_busy_n", bn, FL);
    check("stab_end_busy", 32'(busy_o), 32'd0);
    step();

    // Reset during data bit 3
    valid_i = 1'b1;
    data_i  = 8'hA5;
    step();
    valid_i = 1'b0;
    for (int i = 0; i < 17; i++) step();
    check("mid_pre_tx", 32'(tx_o), 32'd0);
    check("mid_pre_busy", 32'(busy_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("mid_rst_tx", 32'(tx_o), 32'd1);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_ready", 32'(ready_o), 32'd1);
    step();
    rst_i = 1'b0;
    step();
    check("mid_post_busy", 32'(busy_o), 32'd0);
    valid_i = 1'b1;
    data_i  = 8'h3C;
    step();
    valid_i = 1'b0;
    frame("3c", F_3C, 1'b0, bn, rl, er);
    check("3c_busy_n", bn, FL);
    check("3c_end_busy", 32'(busy_o), 32'd0);

`ifdef UART_TX_PARITY_EN
    step();
    valid_i = 1'b1;
    data_i  = 8'h07;
    step();
    valid_i = 1'b0;
    frame("p07", F_07, 1'b0, bn, rl, er);
    check("p07_busy_n", bn, 44);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that sits directly downstream of the packet framer and turns its byte stream into 8N1 UART frames on a single output pin. It accepts one byte per ready/valid handshake, holds it in a shift register, and drives start, data (LSB first), optional parity, and stop bits, each lasting a fixed number of clock cycles. Back-to-back bytes produce frames with no idle gap, so the framer's packet and footer bytes leave the chip at full line rate.

## Interface
- `ClkFreqHz`, default 12_000_000: system clock frequency.
- `BaudRate`, default 115_200: line rate in bits/s.
- `ClksPerBit` (localparam), `ClkFreqHz / BaudRate`, truncated: cycles per bit.
- `clk_i`, input, 1: the only clock.
- `rst_i`, input, 1: reset, asynchronous and active-high.
- `valid_i`, input, 1: `data_i` holds a byte to send.
- `ready_o`, output, 1: the block can accept a byte this cycle.
- `data_i`, input, 8: byte to transmit. Sampled only on handshake.
- `tx_o`, output, 1: serial line. Idles high.
- `busy_o`, output, 1: a frame is in progress.

## Operation
- The state machine has four states: Idle, Start, Data, Stop. Parity is added when configured.
- **Accept:** a handshake (`valid_i && ready_o`) latches `data_i` into the shift register. It also clears the baud counter and the bit index, and the state moves to Start.
- **`ready_o`:** `ready_o = (state == Idle) || (state == Stop && baud_cnt == ClksPerBit-1)`.
  - It is combinational from registered state only. It has no path from `valid_i`.
- **Baud counter:** width `$clog2(ClksPerBit)`. It counts from 0 to `ClksPerBit-1` and then wraps to 0.
  - At each wrap the current bit ends and the state advances.
- **Start:** `tx_o = 0` for one bit period, then go to Data.
- **Data:** `tx_o = shift[0]`. At each bit end the register shifts right and the bit index increments (3 bits).
  - After bit index 7 ends: go to Parity if configured, else Stop.
- **Stop:** `tx_o = 1` for one bit period. At the end:
  - if the handshake fires, go to Start with the new byte;
  - otherwise go to Idle.
- **`busy_o`:** 1 in every state except Idle.
- **`tx_o`:** a register (glitch-free pin), updated on the same edge as the state.
- **Input stability:** changes to `data_i` while busy have no effect. `valid_i` held high with no handshake is not an error.
- **Elaboration checks:**
  - `ClksPerBit < 2` is an elaboration `$error`.
  - A non-integer ratio is allowed; the truncation error is the integrator's responsibility.
- **Reset values** (asserted asynchronously, immediately): state Idle, `tx_o = 1`, `busy_o = 0`, `ready_o = 1`, baud counter 0, bit index 0, shift register 0.
- **Reset mid-frame:** the line returns high at once and the byte is dropped. There is no partial-frame completion.

## Timing
- Take a handshake at rising edge k.
  - The start bit is on `tx_o` from edge k+1 for `ClksPerBit` cycles.
  - Data bit i is driven from edge k+1+(i+1)·`ClksPerBit`.
- Without parity the frame is exactly 10·`ClksPerBit` cycles. With parity it is 11·`ClksPerBit`.
- Back-to-back: `ready_o` is high in the last stop-bit cycle. A handshake there makes the next start bit begin on the very next edge, so there are 0 idle cycles.
- From Idle, a handshake takes effect the same cycle `valid_i` rises. There is no extra latency.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - a Parity state follows Data;
  - it drives the even-parity bit `^byte` for one bit period, then goes to Stop;
  - frame length is 11·`ClksPerBit`.
- `UART_TX_PARITY_EN` undefined: Data goes straight to Stop (8N1), and no parity logic is present.

## Test plan
All scenarios use `ClkFreqHz = 1_000_000` and `BaudRate = 250_000`, so `ClksPerBit = 4`.

- **Single byte:** send 0xA5 from Idle.
  - `tx_o`, sampled every 4 cycles from k+1, must read 0,1,0,1,0,0,1,0,1,1.
  - `busy_o` is high for exactly 40 cycles.
  - `ready_o` is high again at cycle k+40.
- **Back-to-back:** hold `valid_i` high with 0xA5 then 0x5A.
  - The second start bit begins at k+41 with no high gap.
  - 0x5A serialises as 0,0,1,0,1,1,0,1,0,1.
- **Idle hold:** keep `valid_i` low for 100 cycles after reset.
  - `tx_o` stays 1, `busy_o` stays 0, and `ready_o` stays 1 throughout.
- **Input stability:** change `data_i` to 0xFF and toggle `valid_i` during a 0x00 frame.
  - All 8 data bits are 0.
  - No handshake occurs before the last stop-bit cycle.
- **Reset mid-frame:** assert `rst_i` asynchronously during data bit 3 of 0xA5.
  - `tx_o` is 1 and `busy_o` is 0 immediately, without waiting for a clock edge.
  - After release, a send of 0x3C produces a clean frame.
- **Parity (with `UART_TX_PARITY_EN`):**
  - 0xA5 gives parity bit 0 and a 44-cycle frame.
  - 0x07 gives parity bit 1.
